// File: rtl/seq_pkg.sv
// Shared types and constants for the cpu_mem_sequencer slice.
// SEQ_TIMEOUT_EN adds the HALT state used by the optional timeout.
package seq_pkg;

   localparam int unsigned AW_DEF = 32;
   localparam int unsigned DW_DEF = 32;

   localparam logic [31:0] SEQ_NOP = 32'h0000_0013;

`ifdef SEQ_TIMEOUT_EN
   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      DATA,
      COMMIT,
      HALT
   } seq_state_t;
`else
   typedef enum logic [1:0] {
      FETCH,
      DECODE,
      DATA,
      COMMIT
   } seq_state_t;
`endif

endpackage

// File: rtl/seq_timeout.sv
// Wait-cycle counter: cleared while idle, counts unacknowledged request cycles,
// flags the cycle that completes LIMIT waits.
module seq_timeout #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   assign expired = inc && (count == CW'(LIMIT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !expired) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Runs the single-cycle core from one shared variable-latency memory port.
// Optional SEQ_TIMEOUT_EN: bounded waits with sticky err and a HALT state.
module cpu_mem_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned AW             = AW_DEF,
   parameter int unsigned DW             = DW_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] instr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          d_we,
   input  logic          d_re,
   output logic [DW-1:0] rdata,
   output logic          cpu_en,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          err
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   seq_state_t    state, state_d;
   logic [DW-1:0] instr_d, rdata_d, mem_wdata_d;
   logic [AW-1:0] mem_addr_d;
   logic          mem_req_d, mem_we_d, cpu_en_d, busy_d;
   logic          wr, wr_d;

`ifdef SEQ_TIMEOUT_EN
   logic expired;
   logic err_q, err_d;

   seq_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (!mem_req),
      .inc     (mem_req && !mem_ack),
      .expired (expired)
   );

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         instr     <= DW'(SEQ_NOP);
         rdata     <= '0;
         cpu_en    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b1;
         wr        <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_d;
         instr     <= instr_d;
         rdata     <= rdata_d;
         cpu_en    <= cpu_en_d;
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         busy      <= busy_d;
         wr        <= wr_d;
`ifdef SEQ_TIMEOUT_EN
         err_q     <= err_d;
`endif
      end
   end

   // Next state; FETCH and DATA spend one setup cycle with mem_req low
   always_comb begin
      state_d     = state;
      instr_d     = instr;
      rdata_d     = rdata;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      wr_d        = wr;
`ifdef SEQ_TIMEOUT_EN
      err_d       = err_q;
`endif
      case (state)
         FETCH: begin
            if (!mem_req) begin
               mem_addr_d = i_addr;
               mem_we_d   = 1'b0;
               mem_req_d  = 1'b1;
            end else if (mem_ack) begin
               instr_d   = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = DECODE;
            end
         end
         DECODE: begin
            if (d_we) begin
               wr_d    = 1'b1;
               state_d = DATA;
            end else if (d_re) begin
               wr_d    = 1'b0;
               state_d = DATA;
            end else begin
               state_d = COMMIT;
            end
         end
         DATA: begin
            if (!mem_req) begin
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_we_d    = wr;
               mem_req_d   = 1'b1;
            end else if (mem_ack) begin
               if (!wr) rdata_d = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = COMMIT;
            end
         end
         COMMIT: state_d = FETCH;
`ifdef SEQ_TIMEOUT_EN
         HALT:   state_d = HALT;
`endif
         default: state_d = FETCH;
      endcase
`ifdef SEQ_TIMEOUT_EN
      if (expired) begin
         mem_req_d = 1'b0;
         err_d     = 1'b1;
         state_d   = HALT;
      end
`endif
      cpu_en_d = (state_d == COMMIT);
      busy_d   = (state_d != COMMIT);
   end

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Scoreboarded bench for cpu_mem_sequencer: expected bus transactions (with the
// response to return) are queued per scenario and consumed as requests appear.
module tb_cpu_mem_sequencer;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ADD = 32'h0010_80B3; // add x1,x1,x1
   localparam logic [31:0] LW  = 32'h0000_2083; // lw  x1,0(x0)
   localparam logic [31:0] SW  = 32'h0010_2023; // sw  x1,0(x0)

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rd;
      int          delay;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        d_we, d_re, mem_ack;
   logic [31:0] instr, rdata, mem_addr, mem_wdata;
   logic        cpu_en, mem_req, mem_we, busy, err;

   int   errors = 0;
   int   checks = 0;
   txn_t exp_q[$];
   txn_t cur;
   logic req_seen = 1'b0;
   int   wait_cnt = 0;
   int   stray = 0;

   cpu_mem_sequencer #(.AW(32), .DW(32), .TIMEOUT_CYCLES(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_addr    (i_addr),
      .instr     (instr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_we      (d_we),
      .d_re      (d_re),
      .rdata     (rdata),
      .cpu_en    (cpu_en),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One cycle: sample at negedge, score new requests, drive the memory response
   task automatic step();
      @(negedge clk);
      checks++;
      if (cpu_en && mem_req) begin
         errors++;
         $display("FAIL cpu_en_with_req: cpu_en=%b mem_req=%b, required not both high", cpu_en, mem_req);
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      if (mem_req) begin
         checks++;
         if (!req_seen) begin
            req_seen = 1'b1;
            wait_cnt = 0;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_req: addr=%h we=%b, required no request", mem_addr, mem_we);
               cur = '{addr: mem_addr, we: mem_we, wdata: mem_wdata, rd: 32'h0, delay: 1000};
            end else begin
               cur = exp_q.pop_front();
               if (mem_addr !== cur.addr || mem_we !== cur.we || (cur.we && mem_wdata !== cur.wdata)) begin
                  errors++;
                  $display("FAIL req_fields: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                           mem_addr, mem_we, mem_wdata, cur.addr, cur.we, cur.wdata);
               end
            end
         end else if (mem_addr !== cur.addr || mem_we !== cur.we || (cur.we && mem_wdata !== cur.wdata)) begin
            errors++;
            $display("FAIL req_stable: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, cur.addr, cur.we, cur.wdata);
         end
         if (wait_cnt == cur.delay) begin
            mem_ack   = 1'b1;
            mem_rdata = cur.rd;
         end
         wait_cnt++;
         stray = 0;
      end else begin
         req_seen = 1'b0;
         if (stray > 0) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h0000_0055;
            stray--;
         end
      end
   endtask

   task automatic rst_begin();
      reset = 1'b1;
      step();
      step();
      exp_q.delete();
      req_seen = 1'b0;
      stray    = 0;
   endtask

   // Steps until cpu_en; c = cycles stepped, -1 if the budget runs out
   task automatic run_instr(output int c);
      bit found = 0;
      c = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         c++;
         if (cpu_en) found = 1;
      end
      if (!found) c = -1;
   endtask

   task automatic test_reset();
      step(); step(); step();
      checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h required %h", instr, NOP); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", mem_req); end
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b required 0", cpu_en); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b required 1", busy); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rdata); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
         errors++; $display("FAIL reset_bus: addr=%h wdata=%h we=%b required zeros", mem_addr, mem_wdata, mem_we);
      end
   endtask

   task automatic test_alu();
      int c;
      rst_begin();
      i_addr = 32'h0; d_re = 1'b0; d_we = 1'b0;
      exp_q.push_back('{addr: 32'h0, we: 1'b0, wdata: 32'h0, rd: ADD, delay: 0});
      reset = 1'b0;
      run_instr(c);
      // release negedge falls inside cycle 1
      checks++; if (c + 1 !== 4) begin errors++; $display("FAIL alu_commit_cycle: got %0d required 4", c + 1); end
      checks++; if (instr !== ADD) begin errors++; $display("FAIL alu_instr: got %h required %h", instr, ADD); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_busy_commit: got %b required 0", busy); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL alu_req_count: %0d pending, required 0", exp_q.size()); end
      step();
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL alu_pulse_width: got %b required 0", cpu_en); end
   endtask

   task automatic test_load();
      int c;
      rst_begin();
      i_addr = 32'h0; d_re = 1'b1; d_we = 1'b0; d_addr = 32'h0;
      exp_q.push_back('{addr: 32'h0, we: 1'b0, wdata: 32'h0, rd: LW, delay: 0});
      exp_q.push_back('{addr: 32'h0, we: 1'b0, wdata: 32'h0, rd: 32'h0000_00FF, delay: 2});
      reset = 1'b0;
      run_instr(c);
      checks++; if (c + 1 !== 8) begin errors++; $display("FAIL load_commit_cycle: got %0d required 8", c + 1); end
      checks++; if (rdata !== 32'h0000_00FF) begin errors++; $display("FAIL load_rdata: got %h required 000000ff", rdata); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL load_req_count: %0d pending, required 0", exp_q.size()); end
      step();
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL load_pulse_width: got %b required 0", cpu_en); end
   endtask

   task automatic test_store();
      int c;
      rst_begin();
      // d_re also high: the write must win
      i_addr = 32'h0; d_re = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h0000_01FE;
      exp_q.push_back('{addr: 32'h0, we: 1'b0, wdata: 32'h0, rd: SW, delay: 0});
      exp_q.push_back('{addr: 32'h0, we: 1'b1, wdata: 32'h0000_01FE, rd: 32'h0000_0BAD, delay: 3});
      reset = 1'b0;
      run_instr(c);
      checks++; if (c + 1 !== 9) begin errors++; $display("FAIL store_commit_cycle: got %0d required 9", c + 1); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_kept: got %h required 0", rdata); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL store_req_count: %0d pending, required 0", exp_q.size()); end
      step();
      d_we = 1'b0;
   endtask

   task automatic test_back_to_back();
      int c;
      rst_begin();
      i_addr = 32'h100; d_re = 1'b0; d_we = 1'b0;
      exp_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0, rd: ADD, delay: 0});
      reset = 1'b0;
      run_instr(c);
      checks++; if (c + 1 !== 4) begin errors++; $display("FAIL b2b_first_cycle: got %0d required 4", c + 1); end
      // PC advances on the commit edge
      i_addr = 32'h104; d_re = 1'b1; d_addr = 32'h2000_0004;
      exp_q.push_back('{addr: 32'h104, we: 1'b0, wdata: 32'h0, rd: LW, delay: 1});
      exp_q.push_back('{addr: 32'h2000_0004, we: 1'b0, wdata: 32'h0, rd: 32'hCAFE_F00D, delay: 0});
      run_instr(c);
      checks++; if (c !== 7) begin errors++; $display("FAIL b2b_load_cycles: got %0d required 7", c); end
      checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata: got %h required cafef00d", rdata); end
      checks++; if (instr !== LW) begin errors++; $display("FAIL b2b_instr: got %h required %h", instr, LW); end
      i_addr = 32'h108; d_re = 1'b0;
      exp_q.push_back('{addr: 32'h108, we: 1'b0, wdata: 32'h0, rd: ADD, delay: 0});
      run_instr(c);
      checks++; if (c !== 4) begin errors++; $display("FAIL b2b_alu_cycles: got %0d required 4", c); end
      checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata_hold: got %h required cafef00d", rdata); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_req_count: %0d pending, required 0", exp_q.size()); end
      step();
   endtask

   task automatic test_reset_mid();
      int c;
      rst_begin();
      i_addr = 32'h0; d_re = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      exp_q.push_back('{addr: 32'h0, we: 1'b0, wdata: 32'h0, rd: LW, delay: 0});
      exp_q.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0, rd: 32'h55, delay: 100});
      reset = 1'b0;
      for (int i = 0; i < 20 && !(mem_req && mem_addr == 32'h40); i++) step();
      checks++; if (!(mem_req === 1'b1 && mem_addr === 32'h40)) begin
         errors++; $display("FAIL mid_reach_data: req=%b addr=%h, required req=1 addr=00000040", mem_req, mem_addr);
      end
      reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b required 0", mem_req); end
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL mid_cpu_en: got %b required 0", cpu_en); end
      exp_q.delete();
      stray = 2;
      i_addr = 32'h80; d_re = 1'b0;
      step();
      reset = 1'b0;
      exp_q.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0, rd: ADD, delay: 0});
      run_instr(c);
      checks++; if (c + 1 !== 4) begin errors++; $display("FAIL mid_restart_cycle: got %0d required 4", c + 1); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h required 0", rdata); end
      checks++; if (instr !== ADD) begin errors++; $display("FAIL mid_instr: got %h required %h", instr, ADD); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_req_count: %0d pending, required 0", exp_q.size()); end
      step();
   endtask

`ifdef SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int   n = 0;
      logic en_seen = 1'b0;
      rst_begin();
      i_addr = 32'h0; d_re = 1'b0; d_we = 1'b0;
      exp_q.push_back('{addr: 32'h0, we: 1'b0, wdata: 32'h0, rd: ADD, delay: 1000});
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (mem_req) n++;
         else if (n > 0) break;
      end
      checks++; if (n !== 16) begin errors++; $display("FAIL timeout_wait_cycles: got %0d required 16", n); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b required 1", err); end
      for (int i = 0; i < 6; i++) begin
         step();
         if (cpu_en) en_seen = 1'b1;
      end
      checks++; if (en_seen !== 1'b0) begin errors++; $display("FAIL timeout_cpu_en: got %b required 0", en_seen); end
      checks++; if (err !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_halt: err=%b busy=%b required 1 1", err, busy);
      end
      rst_begin();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b required 0", err); end
   endtask
`endif

   initial begin
      reset = 1'b1; i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_re = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_back_to_back();
      test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_mem_sequencer.md
# cpu_mem_sequencer

Multi-cycle sequencer that lets the single-cycle `cpu` core run from one shared, variable-latency memory port instead of separate zero-latency instruction and data memories. Each instruction runs as fetch, decode, optional data access, then commit. The block holds the fetched instruction stable, performs the load or store on the shared bus, and pulses a one-cycle commit enable that gates the core's register file and PC update. It sits between `cpu` and the memory/bus fabric.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT_CYCLES`, default 16: wait-cycle limit, used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `i_addr` input AW: instruction address, from the core's `instrAddr`.
- `instr` output DW: held instruction, to the core's `instr`.
- `d_addr` input AW: data address, from the core's `dataAddr`.
- `d_wdata` input DW: store data, from the core's `writeData`.
- `d_we` input 1: store request, from the core's `we`.
- `d_re` input 1: load request, from the core's decode.
- `rdata` output DW: latched load data, to the core's `readData`.
- `cpu_en` output 1: one-cycle commit strobe; the core updates PC and registers only when it is high.
- `mem_req` output 1: memory request.
- `mem_we` output 1: memory write.
- `mem_addr` output AW: memory address.
- `mem_wdata` output DW: memory write data.
- `mem_ack` input 1: transfer complete; `mem_rdata` is valid in the same cycle for reads.
- `mem_rdata` input DW: memory read data.
- `busy` output 1: high in every state except COMMIT.
- `err` output 1: sticky timeout error.

## Operation
- States:
  - FETCH
  - DECODE
  - DATA
  - COMMIT
  - HALT (exists only with `SEQ_TIMEOUT_EN`)
- Reset values:
  - state = FETCH
  - `instr` = 32'h0000_0013 (nop)
  - `rdata` = 0
  - `mem_req`, `mem_we`, `cpu_en`, `err` = 0
  - `mem_addr`, `mem_wdata` = 0
- FETCH:
  - On the first cycle, register `mem_addr` ← `i_addr` and `mem_we` ← 0; `mem_req` goes high the following cycle.
  - On `mem_ack`: `instr` ← `mem_rdata`, drop `mem_req`, go to DECODE.
- DECODE: one cycle in which the core decodes the held `instr`.
  - If `d_we`: go to DATA as a write.
  - Else if `d_re`: go to DATA as a read.
  - Else: go to COMMIT.
  - If `d_we` and `d_re` are both high, the write wins and `d_re` is ignored.
- DATA:
  - Register `mem_addr` ← `d_addr`, `mem_wdata` ← `d_wdata`, and `mem_we`; raise `mem_req`.
  - On `mem_ack`: for a read, `rdata` ← `mem_rdata`. Drop `mem_req`, go to COMMIT.
- COMMIT: `cpu_en` = 1 for exactly one cycle, then go to FETCH.
- While `mem_req` is high, `mem_addr`, `mem_we` and `mem_wdata` stay stable.
- `mem_ack` is ignored while `mem_req` is low.
- `rdata` holds its value until the next load completes.
- `cpu_en` is never high while `mem_req` is high.
- Addresses pass through unmodified; there is no alignment check.
- Asserting `reset` in any state, including mid-transfer, immediately drops `mem_req` and `cpu_en` and restores every reset value. An outstanding ack arriving after reset is ignored.

## Timing
- With `mem_ack` returned on the cycle `mem_req` first goes high:
  - ALU or branch instruction: 4 cycles (FETCH ×2, DECODE, COMMIT).
  - Load or store: 6 cycles.
- Each memory wait cycle adds exactly one cycle.
- `instr` changes only on the cycle after a fetch ack.
- The core's PC advances on the `clk` edge where `cpu_en` = 1; the next fetch samples `i_addr` after that edge.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A counter clears whenever `mem_req` rises and increments on each cycle with `mem_req` = 1 and `mem_ack` = 0.
  - When it reaches `TIMEOUT_CYCLES`: drop `mem_req`, set `err` = 1, enter HALT.
  - In HALT, `cpu_en` stays 0 and `busy` stays 1; only `reset` leaves HALT.
- `SEQ_TIMEOUT_EN` undefined:
  - The sequencer waits indefinitely for `mem_ack`.
  - `err` is tied to 0; there is no HALT state and no counter.

## Structure
- Package `seq_pkg`: `seq_state_t` enum, `SEQ_NOP` = 32'h0000_0013, and the `AW`/`DW` defaults.
- Sub-module `seq_timeout`: a load/increment/compare counter with `clr`, `inc` and `expired` ports. It is instantiated only under `SEQ_TIMEOUT_EN`.

## Test plan
- **Reset:** hold `reset` = 1 for 3 cycles → `instr` = 0x00000013, `mem_req` = 0, `cpu_en` = 0, `err` = 0, `busy` = 1.
- **Zero-wait ALU instruction:** `i_addr` = 0, `mem_rdata` = add x1,x1,x1, ack immediately, `d_re` = `d_we` = 0 → exactly one `mem_req` (`mem_addr` = 0, `mem_we` = 0); `cpu_en` pulses on cycle 4 after reset release.
- **Load with 2-cycle ack delay:** lw x1,0(x0), `d_addr` = 0, `mem_rdata` = 0x00FF → `rdata` = 0x00FF before `cpu_en`; `cpu_en` pulses once, 8 cycles after the fetch start.
- **Store:** sw, `d_addr` = 0, `d_wdata` = 0x01FE → `mem_we` = 1, `mem_addr` = 0, `mem_wdata` = 0x01FE held until ack; `rdata` unchanged.
- **Reset mid-transfer:** assert `reset` in DATA with `mem_req` high → `mem_req` drops in the same cycle; a later `mem_ack` has no effect; after release, a fetch restarts from the current `i_addr`.
- **Timeout (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16):** no ack → `mem_req` drops after 16 wait cycles, `err` = 1 sticky, `cpu_en` stays 0 until `reset`.
